mux8way_collector: RTL and testbench



---
 rtl/mux8way_collector.sv | 95 +++++++++
 tb/tb_mux8way_collector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mux8way_collector.sv
// Eight-to-one collecting mux with a registered valid/ready output stage.
// Define MUX8WAY_RR_EN for round-robin arbitration; otherwise lowest valid lane wins.
module mux8way_collector #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_valid,
    input  logic [8*WIDTH-1:0] in_data,
    output logic [7:0]         in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [2:0]         out_sel
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr;
    logic [2:0]       idx;
    logic [2:0]       win;
    logic             found;
    logic             load;

`ifdef MUX8WAY_RR_EN
    logic [2:0] ptr_q, ptr_d;

    assign ptr   = ptr_q;
    // 3-bit add wraps lane 7 back to lane 0.
    assign ptr_d = load ? win + 3'd1 : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign ptr = 3'd0;
`endif

    // First valid lane at or after ptr, wrapping modulo 8.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && in_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    // rst_n gates load so no lane is granted while reset is asserted.
    assign load     = found && rst_n && ((state_q == StEmpty) || out_ready);
    assign in_ready = load ? (8'd1 << win) : 8'd0;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
        case (state_q)
            StEmpty: if (load) state_d = StFull;
            StFull:  if (!load && out_ready) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
        if (load) begin
            data_d = in_data[32'(win) * WIDTH +: WIDTH];
            sel_d  = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            data_q  <= '0;
            sel_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux8way_collector.sv
// Bench for mux8way_collector: vector table, hand sequences and an output scoreboard.
// Expectations follow the build: MUX8WAY_RR_EN selects round-robin, else fixed priority.
module tb_mux8way_collector;
    localparam int W = 16;
`ifdef MUX8WAY_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [7:0]     in_valid;
    logic [8*W-1:0] in_data;
    logic [7:0]     in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_sel;

    mux8way_collector #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  v;
        logic        rdy;
        logic [7:0]  exp_ir;
        logic        exp_ov;
        logic [2:0]  exp_sel;
        logic [15:0] exp_data;
    } vec_t;

    vec_t        tbl [8];
    logic [18:0] sb[$];   // {sel, data} of words expected in the output register
    logic [15:0] lane_d [8];
    logic [2:0]  m_ptr;
    int          n_cmp;
    int          n_bad;

    always_comb begin
        in_data = '0;
        for (int k = 0; k < 8; k++) in_data[k*W +: W] = lane_d[k];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called on a falling edge; applies inputs, checks against the model, advances one cycle.
    task automatic cycle(input logic [7:0] v, input logic rdy);
        logic [2:0] w;
        logic [2:0] j;
        logic       f;
        logic       ld;
        logic [7:0] exp_ir;
        in_valid  = v;
        out_ready = rdy;
        #2;
        f = 1'b0;
        w = 3'd0;
        for (int i = 0; i < 8; i++) begin
            j = m_ptr + 3'(i);
            if (!f && v[j]) begin
                f = 1'b1;
                w = j;
            end
        end
        ld     = f && ((sb.size() == 0) || rdy);
        exp_ir = ld ? (8'd1 << w) : 8'd0;
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("sb_data", 32'(out_data), 32'(sb[0][15:0]));
            chk("sb_sel", 32'(out_sel), 32'(sb[0][18:16]));
            if (rdy) void'(sb.pop_front());
        end
        if (ld) begin
            sb.push_back({w, lane_d[w]});
            if (RR) m_ptr = w + 3'd1;
        end
        @(negedge clk);
    endtask

    // Called on a falling edge; reset asserted between edges, released on the next falling edge.
    task automatic async_reset();
        chk("pre_rst_valid", 32'(out_valid), 32'(sb.size() != 0));
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        sb.delete();
        m_ptr = 3'd0;
        @(negedge clk);
        chk("rst_hold_ir", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        m_ptr     = 3'd0;
        rst_n     = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) lane_d[k] = 16'h0100 + 16'(k);

        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_sel", 32'(out_sel), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 8'h00;
        rst_n    = 1'b1;

        // Single lane 5, then FULL with lane 3 / BEEF held under backpressure.
        lane_d[5] = 16'h1234;
        lane_d[3] = 16'hBEEF;
        tbl[0] = '{8'h20, 1'b1, 8'h20, 1'b0, 3'd0, 16'h0000};
        tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 3'd5, 16'h1234};
        tbl[2] = '{8'h08, 1'b1, 8'h08, 1'b0, 3'd5, 16'h1234};
        tbl[3] = '{8'h42, 1'b0, 8'h00, 1'b1, 3'd3, 16'hBEEF};
        tbl[4] = '{8'h42, 1'b0, 8'h00, 1'b1, 3'd3, 16'hBEEF};
        tbl[5] = '{8'h42, 1'b0, 8'h00, 1'b1, 3'd3, 16'hBEEF};
        tbl[6] = '{8'h42, 1'b1, RR ? 8'h40 : 8'h02, 1'b1, 3'd3, 16'hBEEF};
        tbl[7] = '{8'h00, 1'b1, 8'h00, 1'b1, RR ? 3'd6 : 3'd1,
                   RR ? 16'h0106 : 16'h0101};
        for (int r = 0; r < 8; r++) begin
            in_valid  = tbl[r].v;
            out_ready = tbl[r].rdy;
            #1;
            chk($sformatf("tbl%0d_in_ready", r), 32'(in_ready), 32'(tbl[r].exp_ir));
            chk($sformatf("tbl%0d_out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
            chk($sformatf("tbl%0d_out_sel", r), 32'(out_sel), 32'(tbl[r].exp_sel));
            chk($sformatf("tbl%0d_out_data", r), 32'(out_data), 32'(tbl[r].exp_data));
            cycle(tbl[r].v, tbl[r].rdy);
        end
        lane_d[5] = 16'h0105;
        lane_d[3] = 16'h0103;

        // Lanes 2 and 6 contending; fixed priority must never grant lane 6.
        for (int n = 0; n < 6; n++) begin
            if (!RR && n >= 2) chk("fixed_sel", 32'(out_sel), 32'd2);
            cycle(8'h44, 1'b1);
        end
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);

        // All lanes valid from a fresh pointer: sequence 0..7,0 with no bubbles.
        in_valid = 8'hFF;
        async_reset();
        for (int n = 0; n < 12; n++) begin
            if (n >= 1) begin
                chk("sweep_valid", 32'(out_valid), 32'd1);
                chk("sweep_sel", 32'(out_sel), RR ? 32'((n - 1) % 8) : 32'd0);
                chk("sweep_data", 32'(out_data), RR ? 32'(16'h0100 + 16'((n - 1) % 8)) : 32'h0100);
            end
            cycle(8'hFF, 1'b1);
        end

        // Mid-stream reset: output drops at once, first grant afterwards is lane 0.
        async_reset();
        for (int n = 0; n < 4; n++) begin
            if (n >= 1) chk("post_rst_sel", 32'(out_sel), RR ? 32'(n - 1) : 32'd0);
            cycle(8'hFF, 1'b1);
        end
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        chk("final_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
